// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: coordinate width, default 640x480@60 Hz
// timing constants and derived line/frame totals. Renderers import COORD_W.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int CLK_DIV  = 4;
    localparam int H_DISP   = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_DISP   = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;

    // Inclusive range test used for the sync windows.
    function automatic logic in_window(input logic [COORD_W-1:0] v,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-coordinate / sync bus driven by vga_sync_gen and consumed by the
// renderers and the VGA connector. frame_count exists only with FRAME_COUNT_EN.
interface vga_sync_gen_if;
    import vga_pkg::*;

    logic               p_tick;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               video_on;
    logic               hsync;
    logic               vsync;
    logic               frame_tick;
`ifdef FRAME_COUNT_EN
    logic [15:0]        frame_count;
`endif

    modport master (
        output p_tick, x, y, video_on, hsync, vsync, frame_tick
`ifdef FRAME_COUNT_EN
        , frame_count
`endif
    );

    modport slave (
        input p_tick, x, y, video_on, hsync, vsync, frame_tick
`ifdef FRAME_COUNT_EN
        , frame_count
`endif
    );

endinterface

// File: rtl/pixel_tick_gen.sv
// Pixel clock-enable: divides clk by CLK_DIV and pulses p_tick for one clk
// while the divider sits at its last count.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             w_last;

    assign w_last = (r_div >= DIV_LAST);
    assign p_tick = w_last;

    // Free-running divider; >= lets any stray value fall back to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_div <= '0;
        else if (w_last)
            r_div <= '0;
        else
            r_div <= r_div + DIV_W'(1);
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: x/y pixel counters, registered hsync/vsync aligned
// with the counters, combinational video_on and a one-clk frame_tick.
// Optional macro FRAME_COUNT_EN adds a 16-bit wrapping frame counter.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = vga_pkg::CLK_DIV,
    parameter int H_DISP   = vga_pkg::H_DISP,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_DISP   = vga_pkg::V_DISP,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter bit SYNC_ACT = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    vga_sync_gen_if.master  vga
);

    localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] HS_BEG  = COORD_W'(H_DISP + H_FP);
    localparam logic [COORD_W-1:0] HS_END  = COORD_W'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_BEG  = COORD_W'(V_DISP + V_FP);
    localparam logic [COORD_W-1:0] VS_END  = COORD_W'(V_DISP + V_FP + V_SYNC - 1);
    localparam logic [COORD_W-1:0] H_VIS   = COORD_W'(H_DISP);
    localparam logic [COORD_W-1:0] V_VIS   = COORD_W'(V_DISP);

    logic               w_p_tick;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_frame_tick;

    logic               w_x_wrap;
    logic               w_y_wrap;
    logic [COORD_W-1:0] w_x_nxt;
    logic [COORD_W-1:0] w_y_nxt;
    logic               w_hsync_nxt;
    logic               w_vsync_nxt;
    logic               w_frame_end;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .p_tick (w_p_tick)
    );

    // Next-state counters and the sync levels they imply.
    always_comb begin
        w_x_wrap    = (r_x >= H_LAST);
        w_y_wrap    = (r_y >= V_LAST);
        w_x_nxt     = w_x_wrap ? '0 : r_x + COORD_W'(1);
        w_y_nxt     = r_y;
        if (w_x_wrap)
            w_y_nxt = w_y_wrap ? '0 : r_y + COORD_W'(1);
        w_hsync_nxt = in_window(w_x_nxt, HS_BEG, HS_END) ? SYNC_ACT : ~SYNC_ACT;
        w_vsync_nxt = in_window(w_y_nxt, VS_BEG, VS_END) ? SYNC_ACT : ~SYNC_ACT;
        w_frame_end = w_x_wrap && w_y_wrap;
    end

    // Counters and syncs advance together on each pixel tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_hsync <= ~SYNC_ACT;
            r_vsync <= ~SYNC_ACT;
        end else if (w_p_tick) begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_hsync <= w_hsync_nxt;
            r_vsync <= w_vsync_nxt;
        end
    end

    // frame_tick is high in the clk that follows the wrap to (0, 0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_frame_tick <= 1'b0;
        else
            r_frame_tick <= w_p_tick && w_frame_end;
    end

`ifdef FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    // Frame counter steps on the same edge that raises frame_tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_frame_count <= '0;
        else if (w_p_tick && w_frame_end)
            r_frame_count <= r_frame_count + 16'd1;
    end

    assign vga.frame_count = r_frame_count;
`endif

    assign vga.p_tick     = w_p_tick;
    assign vga.x          = r_x;
    assign vga.y          = r_y;
    assign vga.video_on   = (r_x < H_VIS) && (r_y < V_VIS);
    assign vga.hsync      = r_hsync;
    assign vga.vsync      = r_vsync;
    assign vga.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance for the divider and
// line timing, plus a tiny-timing instance so whole frames fit in a short run.
module tb_vga_sync_gen;

    // Small instance timing: 23 pixels x 12 lines, divide by 3.
    localparam int S_DIV = 3;
    localparam int S_HD = 16, S_HFP = 2, S_HS = 3, S_HBP = 2;
    localparam int S_VD = 6,  S_VFP = 2, S_VS = 2, S_VBP = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   e = 0;          // rising edges since reset release
    int   n_checks = 0;
    int   n_err = 0;
`ifdef FRAME_COUNT_EN
    logic [15:0] exp_fc = '0;
`endif

    always #5 clk = ~clk;

    vga_sync_gen_if d_if ();
    vga_sync_gen_if s_if ();

    vga_sync_gen u_d (
        .clk   (clk),
        .reset (reset),
        .vga   (d_if)
    );

    vga_sync_gen #(
        .CLK_DIV (S_DIV),
        .H_DISP (S_HD), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_DISP (S_VD), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
        .SYNC_ACT (1'b0)
    ) u_s (
        .clk   (clk),
        .reset (reset),
        .vga   (s_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, e, obs, exp_v);
        end
    endtask

    // Reference: the n-th edge after release completes floor(n/div) pixel
    // periods; position, syncs and frame pulse follow from plain arithmetic.
    task automatic check_one(input string p, input int div,
                             input int hd, input int hfp, input int hs, input int hbp,
                             input int vd, input int vfp, input int vs, input int vbp,
                             input logic o_pt, input logic [9:0] o_x, input logic [9:0] o_y,
                             input logic o_von, input logic o_hs, input logic o_vs,
                             input logic o_ft);
        int ht, vt, k, ex, ey;
        logic ept, eft, ehs, evs, evon;
        ht   = hd + hfp + hs + hbp;
        vt   = vd + vfp + vs + vbp;
        k    = e / div;
        ex   = k % ht;
        ey   = (k / ht) % vt;
        ept  = (e % div) == (div - 1);
        eft  = (e > 0) && (e % div == 0) && (k % (ht * vt) == 0);
        ehs  = !((ex >= hd + hfp) && (ex < hd + hfp + hs));
        evs  = !((ey >= vd + vfp) && (ey < vd + vfp + vs));
        evon = (ex < hd) && (ey < vd);
        chk({p, ".p_tick"},     32'(o_pt),  32'(ept));
        chk({p, ".x"},          32'(o_x),   32'(ex));
        chk({p, ".y"},          32'(o_y),   32'(ey));
        chk({p, ".video_on"},   32'(o_von), 32'(evon));
        chk({p, ".hsync"},      32'(o_hs),  32'(ehs));
        chk({p, ".vsync"},      32'(o_vs),  32'(evs));
        chk({p, ".frame_tick"}, 32'(o_ft),  32'(eft));
    endtask

    task automatic check_all();
        check_one("D", 4, 640, 16, 96, 48, 480, 10, 2, 33,
                  d_if.p_tick, d_if.x, d_if.y, d_if.video_on, d_if.hsync, d_if.vsync, d_if.frame_tick);
        check_one("S", S_DIV, S_HD, S_HFP, S_HS, S_HBP, S_VD, S_VFP, S_VS, S_VBP,
                  s_if.p_tick, s_if.x, s_if.y, s_if.video_on, s_if.hsync, s_if.vsync, s_if.frame_tick);
`ifdef FRAME_COUNT_EN
        chk("S.frame_count", 32'(s_if.frame_count), 32'(exp_fc));
`endif
    endtask

    // One clock of free running, then a check away from the edge.
    task automatic step();
        @(posedge clk);
        e++;
`ifdef FRAME_COUNT_EN
        if ((e % S_DIV == 0) &&
            ((e / S_DIV) % ((S_HD + S_HFP + S_HS + S_HBP) * (S_VD + S_VFP + S_VS + S_VBP)) == 0))
            exp_fc = exp_fc + 16'd1;
`endif
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset landing mid-cycle, held a few clocks, released on a negedge.
    task automatic mid_reset(input int hold);
        @(posedge clk);
        e++;
        #3;
        reset = 1'b1;
        e = 0;
`ifdef FRAME_COUNT_EN
        exp_fc = '0;
`endif
        #1;
        check_all();
        repeat (hold) begin
            @(negedge clk);
            check_all();
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset held for 5 clocks, checked each cycle.
        repeat (5) begin
            @(negedge clk);
            check_all();
        end
        reset = 1'b0;

        // Two full default lines (line timing, hsync window) and several small frames.
        repeat (7000) step();

        // Land a reset near x=700 of the default line, then check the restart.
        while (!(e / 4 % 800 == 699 && e % 4 == 3)) step();
        mid_reset($urandom_range(1, 5));
`ifdef FRAME_COUNT_EN
        @(negedge clk);
        check_all();
        force u_s.r_frame_count = 16'hFFFF;
        #1;
        release u_s.r_frame_count;
        exp_fc = 16'hFFFF;
        e++;
        @(negedge clk);
        check_all();
        repeat (1000) step();
`else
        repeat (1000) step();
`endif

        // Randomly placed reset pulses with random run lengths in between.
        repeat (4) begin
            repeat ($urandom_range(50, 2500)) step();
            mid_reset($urandom_range(0, 4));
        end

        // Long enough for three small frames after the last restart.
        repeat (3 * S_DIV * 23 * 12 + 50) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
